arf_retire_sched: RTL
=====================

// Module: arf_retire_sched
// PURPOSE
// - Retirement scheduler sitting between ROB head and the Architectural Register File (ARF).
// - Buffers up to 2 retiring results per cycle in an in-order FIFO and drains up to 2 per cycle onto the ARF dual write port.
// - Suppresses same-address write pairs, honours ARF stall, supports pipeline flush.
// PARAMETERS
// AR_SIZE     6   width of register address (ARF has 2**AR_SIZE entries)
// DATA_W      32  register data width
// FIFO_DEPTH  8   retire buffer entries; power of 2, >= 4
// PORTS
// clk           in   1        rising-edge clock
// rstn          in   1        async active-low reset
// enq_valid     in   2        retire slot valid; bit0 = older slot; 2'b10 illegal
// enq_addr0/1   in   AR_SIZE  renamed destination reg of slot 0/1
// enq_data0/1   in   DATA_W   result value of slot 0/1
// enq_old0/1    in   6        architectural reg id of slot 0/1 (debug/trace)
// enq_ready     out  1        buffer accepts 2 entries this cycle
// flush         in   1        discard all buffered entries
// arf_stall     in   1        ARF write port unavailable this cycle
// write_addr1/2 out  AR_SIZE  ARF write addr port 1 (older) / port 2 (younger)
// write_data1/2 out  DATA_W   ARF write data
// old_addr1/2   out  6        ARF trace id
// write_en      out  1        ARF write strobe
// occupancy     out  log2(FIFO_DEPTH)+1  buffered entry count
// retire_cnt    out  32       total entries drained, wraps mod 2**32
// err_sticky    out  1        set on illegal enq_valid 2'b10, cleared only by reset
// BEHAVIOUR
// - Reset (async, rstn=0): pointers/occupancy=0, all write_* / old_* =0, write_en=0, retire_cnt=0, err_sticky=0, state RUN.
// - States: RUN, FLUSH. RUN->FLUSH when flush=1; FLUSH->RUN unconditionally next cycle.
// - enq_ready = (state==RUN) && (FIFO_DEPTH - occupancy >= 2); uses current occupancy, ignores same-cycle pops.
// - Enqueue (RUN, enq_ready=1, flush=0): 2'b01 pushes slot0; 2'b11 pushes slot0 then slot1; 2'b10 pushes nothing, sets err_sticky.
// - enq_valid while enq_ready=0 is dropped; upstream holds it.
// - Dequeue (RUN, arf_stall=0, flush=0): pop n = min(occupancy,2) oldest entries; at next edge register them: oldest -> port1, next -> port2.
// - write_en=1 iff n>0.
// - n=1: port2 addr/data/old = 0.
// - Collision: n=2 and both addrs equal and nonzero -> write_addr1 forced 0 (older write suppressed, younger wins); data1/old1 still driven.
// - addr 0 entries drained normally (ARF ignores p0).
// - retire_cnt += n including suppressed/p0 entries.
// - Latency: entry accepted at edge k appears on write port after edge k+1 at earliest. No enqueue-to-write bypass.
// - Simultaneous enq and deq: occupancy_next = occupancy + pushed - popped.
// - Pointers wrap modulo FIFO_DEPTH.
// - arf_stall=1: no pop; write_en=0 next cycle; outputs otherwise hold; enqueue continues.
// - flush=1 (priority over stall and enqueue): at next edge pointers/occupancy=0, write_en=0, write_* cleared, enqueue that cycle ignored.
// - FLUSH state: enq_ready=0, no pop; flush repeated in FLUSH stays FLUSH.
// - write_* registered outputs; no combinational path from enq_* to write_*.
// STRUCTURE
// - Shared package riscv_ooo_pkg:
//   - constants AR_SIZE, DATA_W
//   - typedef retire_entry_t {addr, data, old}
//   - enum sched_state_t {RUN, FLUSH}
// - One sub-module retire_fifo: 2-push/2-pop circular buffer of retire_entry_t with occupancy and sync clear.
// - Scheduler FSM, collision check and output registers live in arf_retire_sched.
// TESTING
// 1. Reset mid-drain (occupancy 5, rstn pulsed low between edges) -> immediately write_en=0, occupancy=0, retire_cnt=0.
// 2. enq_valid=11 {p5=100,p6=200} once -> next edge write_en=1, addr1=5 data1=100, addr2=6 data2=200; retire_cnt=2.
// 3. 9 single pushes with arf_stall=1 -> enq_ready=0 at occupancy 7; release stall, drain 2,2,2,1 in FIFO order; retire_cnt=7.
// 4. Pair {p9=1, p9=2} -> write_addr1=0, write_addr2=9 data2=2, write_en=1.
// 5. Occupancy 6, flush with enq_valid=11 -> next cycle occupancy=0, write_en=0, enq_ready=0; following cycle enq_ready=1.
// 6. enq_valid=10 -> nothing pushed, err_sticky=1 held until reset; pointer wrap over 20 pushes keeps order intact.

Source files
------------

// File: rtl/riscv_ooo_pkg.sv
// rtl/riscv_ooo_pkg.sv - shared types and constants for the retirement scheduler
package riscv_ooo_pkg;

   localparam int AR_SIZE = 6;
   localparam int DATA_W  = 32;
   localparam int OLD_W   = 6;

   typedef struct packed {
      logic [AR_SIZE-1:0] addr;
      logic [DATA_W-1:0]  data;
      logic [OLD_W-1:0]   old;
   } retire_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } sched_state_t;

endpackage

// File: rtl/arf_retire_sched_if.sv
// rtl/arf_retire_sched_if.sv - retire-slot enqueue and ARF dual write port bundle
interface arf_retire_sched_if;
   import riscv_ooo_pkg::*;

   logic [1:0]         enq_valid;
   logic [AR_SIZE-1:0] enq_addr0;
   logic [AR_SIZE-1:0] enq_addr1;
   logic [DATA_W-1:0]  enq_data0;
   logic [DATA_W-1:0]  enq_data1;
   logic [OLD_W-1:0]   enq_old0;
   logic [OLD_W-1:0]   enq_old1;
   logic               enq_ready;

   logic               arf_stall;
   logic [AR_SIZE-1:0] write_addr1;
   logic [AR_SIZE-1:0] write_addr2;
   logic [DATA_W-1:0]  write_data1;
   logic [DATA_W-1:0]  write_data2;
   logic [OLD_W-1:0]   old_addr1;
   logic [OLD_W-1:0]   old_addr2;
   logic               write_en;

   modport master (
      output enq_valid, enq_addr0, enq_addr1, enq_data0, enq_data1, enq_old0, enq_old1,
      output arf_stall,
      input  enq_ready,
      input  write_addr1, write_addr2, write_data1, write_data2, old_addr1, old_addr2, write_en
   );

   modport slave (
      input  enq_valid, enq_addr0, enq_addr1, enq_data0, enq_data1, enq_old0, enq_old1,
      input  arf_stall,
      output enq_ready,
      output write_addr1, write_addr2, write_data1, write_data2, old_addr1, old_addr2, write_en
   );

endinterface

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - 2-push/2-pop circular buffer of retire entries with sync clear
module retire_fifo
   import riscv_ooo_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    clear,
   input  logic [1:0]              push_cnt,
   input  retire_entry_t           push0,
   input  retire_entry_t           push1,
   input  logic [1:0]              pop_cnt,
   output retire_entry_t           head0,
   output retire_entry_t           head1,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   retire_entry_t mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_nxt;
   logic [PW-1:0] rd_nxt;

   // Power-of-two depth lets the pointer adders wrap for free.
   assign wr_nxt = wr_ptr + PW'(1);
   assign rd_nxt = rd_ptr + PW'(1);
   assign head0  = mem[rd_ptr];
   assign head1  = mem[rd_nxt];

   always_ff @(posedge clk) begin
      if (push_cnt != 2'd0) begin
         mem[wr_ptr] <= push0;
      end
      if (push_cnt == 2'd2) begin
         mem[wr_nxt] <= push1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push_cnt);
         rd_ptr <= rd_ptr + PW'(pop_cnt);
         count  <= count + CW'(push_cnt) - CW'(pop_cnt);
      end
   end

endmodule

// File: rtl/arf_retire_sched.sv
// rtl/arf_retire_sched.sv - retirement scheduler: buffers ROB retires, drains pairs onto the ARF
module arf_retire_sched
   import riscv_ooo_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush,
   arf_retire_sched_if.slave            bus,
   output logic [$clog2(FIFO_DEPTH):0]  occupancy,
   output logic [31:0]                  retire_cnt,
   output logic                         err_sticky
);

   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   sched_state_t  state;
   logic          run;
   logic [1:0]    push_cnt;
   logic [1:0]    pop_cnt;
   logic          collide;
   retire_entry_t push0;
   retire_entry_t push1;
   retire_entry_t head0;
   retire_entry_t head1;

   assign run           = (state == RUN);
   assign bus.enq_ready = run && (occupancy <= OCC_W'(FIFO_DEPTH - 2));

   assign push0 = '{addr: bus.enq_addr0, data: bus.enq_data0, old: bus.enq_old0};
   assign push1 = '{addr: bus.enq_addr1, data: bus.enq_data1, old: bus.enq_old1};

   always_comb begin
      push_cnt = 2'd0;
      if (bus.enq_ready && !flush) begin
         case (bus.enq_valid)
            2'b01:   push_cnt = 2'd1;
            2'b11:   push_cnt = 2'd2;
            default: push_cnt = 2'd0;
         endcase
      end
   end

   always_comb begin
      pop_cnt = 2'd0;
      if (run && !flush && !bus.arf_stall) begin
         if (occupancy >= OCC_W'(2)) begin
            pop_cnt = 2'd2;
         end else if (occupancy != '0) begin
            pop_cnt = 2'd1;
         end
      end
   end

   // Same-cycle writes to one register: only the younger may land; p0 never collides.
   assign collide = (pop_cnt == 2'd2) && (head0.addr == head1.addr) && (head0.addr != '0);

   retire_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (flush),
      .push_cnt (push_cnt),
      .push0    (push0),
      .push1    (push1),
      .pop_cnt  (pop_cnt),
      .head0    (head0),
      .head1    (head1),
      .count    (occupancy)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= RUN;
         err_sticky      <= 1'b0;
         retire_cnt      <= '0;
         bus.write_en    <= 1'b0;
         bus.write_addr1 <= '0;
         bus.write_addr2 <= '0;
         bus.write_data1 <= '0;
         bus.write_data2 <= '0;
         bus.old_addr1   <= '0;
         bus.old_addr2   <= '0;
      end else begin
         case (state)
            RUN:     state <= flush ? FLUSH : RUN;
            FLUSH:   state <= flush ? FLUSH : RUN;
            default: state <= RUN;
         endcase

         if (bus.enq_ready && !flush && (bus.enq_valid == 2'b10)) begin
            err_sticky <= 1'b1;
         end

         retire_cnt <= retire_cnt + 32'(pop_cnt);

         if (flush) begin
            bus.write_en    <= 1'b0;
            bus.write_addr1 <= '0;
            bus.write_addr2 <= '0;
            bus.write_data1 <= '0;
            bus.write_data2 <= '0;
            bus.old_addr1   <= '0;
            bus.old_addr2   <= '0;
         end else if (pop_cnt != 2'd0) begin
            bus.write_en    <= 1'b1;
            bus.write_addr1 <= collide ? '0 : head0.addr;
            bus.write_data1 <= head0.data;
            bus.old_addr1   <= head0.old;
            if (pop_cnt == 2'd2) begin
               bus.write_addr2 <= head1.addr;
               bus.write_data2 <= head1.data;
               bus.old_addr2   <= head1.old;
            end else begin
               bus.write_addr2 <= '0;
               bus.write_data2 <= '0;
               bus.old_addr2   <= '0;
            end
         end else begin
            bus.write_en <= 1'b0;
         end
      end
   end

endmodule
